bk_multiword_seq: RTL and testbench
===================================

Name: bk_multiword_seq

Overview:
Multi-precision add/subtract sequencer that drives the 16-bit Brent-Kung adder one word per cycle and collects its results.
- Feeds the adder's A/B/cin.
- Consumes its sum/cout.
- Chains each cout into the next word's carry-in to form a WORDS×16-bit result.
- Uses valid/ready handshakes on both the operand side and the result side.

Parameters:
WORDS, 4, number of 16-bit words per operand (≥2); total width W = 16*WORDS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  sequencer can accept an operand.
in_a  input  W  operand A.
in_b  input  W  operand B.
in_cin  input  1  carry-in; ignored when in_sub=1.
in_sub  input  1  1 = A-B, 0 = A+B+cin.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  W  result.
out_cout  output  1  final carry. For sub this is the not-borrow flag.
out_ovf  output  1  signed two's-complement overflow.
adder_a  output  16  word to adder A.
adder_b  output  16  word to adder B.
adder_cin  output  1  carry to adder cin.
adder_sum  input  16  adder sum, combinational same cycle.
adder_cout  input  1  adder cout, combinational same cycle.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state = IDLE; word index = 0; carry register = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_valid = 0.
  - in_ready = 1 once rst_n is released.
- States and transitions:
  - IDLE:
    - in_ready = 1.
    - On an edge with in_valid=1: capture in_a into the A register.
    - Capture the B register as in_sub ? ~in_b : in_b.
    - Set carry = in_sub ? 1 : in_cin, and capture in_sub.
    - Set idx = 0; go to RUN.
  - RUN:
    - in_ready = 0.
    - Drive adder_a = A[16*idx+:16], adder_b = Beff[16*idx+:16], adder_cin = carry.
    - Each edge: result[16*idx+:16] <= adder_sum; carry <= adder_cout; idx++.
    - On the edge where idx = WORDS-1 is consumed, go to DONE.
  - DONE:
    - out_valid = 1; in_ready = 0.
    - Outputs held stable while out_ready=0.
    - On an edge with out_ready=1, go to IDLE. out_valid drops the following cycle.
- Outputs while DONE:
  - out_sum = result register.
  - out_cout = final carry.
  - out_ovf = (A[W-1] == Beff[W-1]) && (out_sum[W-1] != A[W-1]).
  - out_sum, out_cout and out_ovf keep the last result after leaving DONE until the next result overwrites them.
- Adder drive: adder_a, adder_b and adder_cin are 0 in IDLE and DONE.
- Latency: the accept edge is T0. Edges T1..T_WORDS latch words 0..WORDS-1. out_valid is high from T_WORDS.
- Throughput: with out_ready tied high, at most one operation per WORDS+2 cycles; there is no accept in the same cycle as the output handshake.
- Operand capture: in_a/in_b/in_cin/in_sub are sampled only at the accept edge. Later changes have no effect on the operation in flight.
- in_valid asserted while busy: ignored; in_ready stays 0. The requester holds its request under standard valid/ready rules.
- Carry wrap: the carry out of word WORDS-1 goes only to out_cout and is never fed back.
- Reset mid-operation: the operation is aborted and all state returns to reset values; no partial result is ever presented.
- Results are not a function of any adder output sampled outside RUN.

Test Plan:
1. WORDS=4, add, in_a=64'hFFFF_FFFF_FFFF_FFFF, in_b=1, cin=0 -> out_sum=0, out_cout=1, out_ovf=0; out_valid rises exactly 4 edges after accept; adder_cin sequence 0,1,1,1.
2. Sub, in_a=5, in_b=7 -> out_sum=64'hFFFF_FFFF_FFFF_FFFE, out_cout=0 (borrow), out_ovf=0. Then in_a=7, in_b=5 -> out_sum=2, out_cout=1.
3. Overflow: add 64'h7FFF_FFFF_FFFF_FFFF + 1 -> out_sum=64'h8000_0000_0000_0000, out_ovf=1. Sub 64'h8000_0000_0000_0000 - 1 -> out_ovf=1, out_sum=64'h7FFF_FFFF_FFFF_FFFF.
4. Backpressure: out_ready held low 3 cycles after out_valid -> out_sum/out_cout stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> handshake, then in_ready=1 next cycle.
5. Back-to-back with in_valid and out_ready tied high, random operands, 100 ops -> every result matches the reference model; accept edges are spaced exactly 6 cycles apart.
6. Assert rst_n=0 during RUN at idx=2 -> all outputs go to 0 immediately (async). After release: in_ready=1, out_valid=0, and the next operation (in_cin=1, add 0+0) yields out_sum=1.

Source files
------------

// File: rtl/bk_multiword_seq.sv
// rtl/bk_multiword_seq.sv - multi-word add/subtract sequencer driving an external 16-bit adder
module bk_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf,
  output logic [15:0]           adder_a,
  output logic [15:0]           adder_b,
  output logic                  adder_cin,
  input  logic [15:0]           adder_sum,
  input  logic                  adder_cout
);

  localparam int W  = 16 * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;      // already inverted for subtraction
  logic [W-17:0] work;       // lower words of the result being built
  logic          carry;
  logic [IW-1:0] idx;
  logic          last_word;

  assign last_word = (idx == IW'(WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic, handshake outputs and adder drive (adder idle outside RUN)
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        adder_a   = a_reg[16*idx +: 16];
        adder_b   = b_reg[16*idx +: 16];
        adder_cin = carry;
        if (last_word) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, word-by-word accumulation and result publication.
  // The visible result registers change only on the final word edge, so a
  // previous result stays intact while the next operation is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_sub ? ~in_b : in_b;
            carry <= in_sub ? 1'b1 : in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          carry <= adder_cout;
          idx   <= idx + 1'b1;
          if (last_word) begin
            out_sum  <= {adder_sum, work};
            out_cout <= adder_cout;
            out_ovf  <= (a_reg[W-1] == b_reg[W-1]) && (adder_sum[15] != a_reg[W-1]);
          end else begin
            work[16*idx +: 16] <= adder_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bk_multiword_seq.sv
// tb/tb_bk_multiword_seq.sv - self-checking bench for bk_multiword_seq with a behavioural 16-bit adder
module tb_bk_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [15:0]   adder_a;
  logic [15:0]   adder_b;
  logic          adder_cin;
  logic [15:0]   adder_sum;
  logic          adder_cout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + 17'(adder_cin);

  bk_multiword_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on whole operands; overflow from the true signed result range
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s);
    res_t r;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] t;
    logic [64:0] u;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    if (s) begin
      t      = sa - sb;
      r.sum  = a - b;
      r.cout = (a >= b);
    end else begin
      t      = sa + sb + 66'(c);
      u      = {1'b0, a} + {1'b0, b} + 65'(c);
      r.sum  = u[63:0];
      r.cout = u[64];
    end
    r.ovf = (t > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (t < -66'sh0_8000_0000_0000_0000);
    return r;
  endfunction

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c, input logic s,
                        output res_t r, output int lat, output logic [3:0] cseq);
    int k;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; in_sub = s; in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", 64'(k < 50), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_a = '1; in_b = '1; in_cin = 1'b1; in_sub = ~s;
    lat  = 0;
    cseq = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (lat < 4) cseq[lat] = adder_cin;
      lat++;
    end
    r.sum  = out_sum;
    r.cout = out_cout;
    r.ovf  = out_ovf;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t        tbl[10];
  res_t        r;
  res_t        e;
  res_t        expq[$];
  int          lat;
  logic [3:0]  cseq;
  logic [63:0] held;
  int          n_acc, n_res, cyc, last_acc;
  logic        acc_now;

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    tbl[1] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[2] = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    tbl[6] = '{64'd0, 64'd0, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0};
    tbl[7] = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
    tbl[8] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 64'h0001_0000_0001_0000, 1'b0, 1'b0};
    tbl[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_adder_a", 64'(adder_a), 64'd0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, r, lat, cseq);
      check($sformatf("tbl%0d_sum", i), r.sum, tbl[i].sum);
      check($sformatf("tbl%0d_cout", i), 64'(r.cout), 64'(tbl[i].cout));
      check($sformatf("tbl%0d_ovf", i), 64'(r.ovf), 64'(tbl[i].ovf));
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd4);
      if (i == 0) check("tbl0_cin_seq", 64'(cseq), 64'(4'b1110));
      @(negedge clk);
      check($sformatf("tbl%0d_valid_drop", i), 64'(out_valid), 64'd0);
      check($sformatf("tbl%0d_ready_back", i), 64'(in_ready), 64'd1);
      check($sformatf("tbl%0d_adder_idle", i), 64'({adder_a, adder_b, adder_cin}), 64'd0);
    end

    // Backpressure: result held while out_ready low, new request ignored
    @(negedge clk);
    in_a = 64'd3; in_b = 64'd4; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    in_valid = 1'b1; in_a = 64'h1111; in_b = 64'h2222;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
      check($sformatf("bp%0d_sum", i), out_sum, 64'd7);
      check($sformatf("bp%0d_cout", i), 64'(out_cout), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", 64'(out_valid), 64'd0);
    check("bp_ready_back", 64'(in_ready), 64'd1);
    check("bp_sum_kept", out_sum, 64'd7);
    repeat (6) @(negedge clk);
    check("bp_no_ghost_op", 64'(out_valid), 64'd0);

    // Back-to-back random operations against the reference model
    n_acc = 0; n_res = 0; cyc = 0; last_acc = -1;
    @(negedge clk);
    in_a = {$urandom(), $urandom()}; in_b = {$urandom(), $urandom()};
    in_cin = 1'($urandom()); in_sub = 1'($urandom());
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_res < 100 && cyc < 2000) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("rnd_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check($sformatf("rnd%0d_sum", n_res), out_sum, e.sum);
          check($sformatf("rnd%0d_cout", n_res), 64'(out_cout), 64'(e.cout));
          check($sformatf("rnd%0d_ovf", n_res), 64'(out_ovf), 64'(e.ovf));
        end
        n_res++;
      end
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        expq.push_back(model(in_a, in_b, in_cin, in_sub));
        if (last_acc >= 0) check($sformatf("rnd%0d_spacing", n_acc), 64'(cyc - last_acc), 64'd6);
        last_acc = cyc;
        n_acc++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (acc_now) begin
        case ($urandom_range(3))
          0: begin in_a = {$urandom(), $urandom()}; in_b = ~in_a; end
          1: begin in_a = '1; in_b = 64'($urandom_range(3)); end
          default: begin in_a = {$urandom(), $urandom()}; in_b = {$urandom(), $urandom()}; end
        endcase
        in_cin = 1'($urandom()); in_sub = 1'($urandom());
        if (n_acc >= 100) in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("rnd_result_count", 64'(n_res), 64'd100);
    out_ready = 1'b0; in_valid = 1'b0;

    // Reset in the middle of RUN (word index 2)
    @(negedge clk);
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h1111_1111_1111_1111; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("mid_adder_a_word2", 64'(adder_a), 64'h5678);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", out_sum, 64'd0);
    check("mid_rst_cout", 64'(out_cout), 64'd0);
    check("mid_rst_ovf", 64'(out_ovf), 64'd0);
    check("mid_rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 64'(in_ready), 64'd1);
    check("mid_rel_valid", 64'(out_valid), 64'd0);
    run_op(64'd0, 64'd0, 1'b1, 1'b0, r, lat, cseq);
    check("post_rst_sum", r.sum, 64'd1);
    check("post_rst_latency", 64'(lat), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
